mux_arb_n: RTL

- Parametrised registered N-input, WIDTH-bit source selector; next generation of the 16-bit 4-to-1 operand mux.
- Adds a per-input valid/ready handshake, a registered output stage with backpressure, and a runtime mode: direct select (S chooses the source) or round-robin arbitration among valid inputs.
- Sits between operand/result producers (register file, ALU, memory read) and a single consumer in the datapath.

---
 rtl/misp_mux_pkg.sv | 19 +
 rtl/rr_pick_n.sv | 38 +++
 rtl/mux_arb_n.sv | 113 +++++++++++
 3 files changed

// File: rtl/misp_mux_pkg.sv
// misp_mux_pkg: shared definitions for the registered N-input source selector.
//   MODE_DIRECT / MODE_RR : values of the Mode input.
//   out_state_e           : output register occupancy (EMPTY / FULL).
//   clog2_min1            : select-index width, never less than one bit.
package misp_mux_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_RR     = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick_n.sv
// rr_pick_n: combinational round-robin search.
//   valid [N]     : request vector.
//   ptr   [SEL_W] : highest-priority index (assumed < N).
//   grant [SEL_W] : first valid index at or after ptr, wrapping modulo N.
//   found         : at least one request is valid.
module rr_pick_n
   import misp_mux_pkg::*;
#(
   parameter  int N     = 4,
   localparam int SEL_W = clog2_min1(N)
) (
   input  logic [N-1:0]     valid,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] grant,
   output logic             found
);

   // Two constant-index passes instead of a modulo walk: the first covers
   // ptr..N-1, the second (only reached when that range is idle) picks the
   // lowest index below ptr, which is the wrapped continuation.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && valid[i] && (i >= 32'(ptr))) begin
            found = 1'b1;
            grant = SEL_W'(i);
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && valid[i]) begin
            found = 1'b1;
            grant = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: registered N-input, WIDTH-bit source selector with per-input
// valid/ready handshake, output backpressure and direct / round-robin mode.
//   CLK, Reset : clock, synchronous active-high reset.
//   In         : flattened inputs, input i at In[i*WIDTH +: WIDTH].
//   In_Valid   : per-input data present.
//   In_Ready   : per-input accepted this cycle (combinational).
//   S          : source index in direct mode.
//   Mode       : MODE_DIRECT (S selects) or MODE_RR (round-robin).
//   Out        : registered selected data.
//   Out_Sel    : index of the input that produced Out.
//   Out_Valid  : Out holds an unconsumed word.
//   Out_Ready  : consumer takes Out this cycle.
module mux_arb_n
   import misp_mux_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int N     = 4,
   localparam int SEL_W = clog2_min1(N)
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [N*WIDTH-1:0] In,
   input  logic [N-1:0]       In_Valid,
   output logic [N-1:0]       In_Ready,
   input  logic [SEL_W-1:0]   S,
   input  logic               Mode,
   output logic [WIDTH-1:0]   Out,
   output logic [SEL_W-1:0]   Out_Sel,
   output logic               Out_Valid,
   input  logic               Out_Ready
);

   out_state_e       state, state_next;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] rr_grant, dir_grant, grant;
   logic             rr_found, dir_found, found;
   logic             load, xfer;
   logic [WIDTH-1:0] sel_data;

   rr_pick_n #(.N(N)) u_pick (
      .valid (In_Valid),
      .ptr   (rr_ptr),
      .grant (rr_grant),
      .found (rr_found)
   );

   // Direct path: S values with no matching input (S >= N) never grant.
   always_comb begin
      dir_grant = S;
      dir_found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (S == SEL_W'(i)) dir_found = In_Valid[i];
      end
   end

   always_comb begin
      grant = dir_grant;
      found = dir_found;
      if (Mode == MODE_RR) begin
         grant = rr_grant;
         found = rr_found;
      end
   end

   assign load = (state == ST_EMPTY) || Out_Ready;
   // Reset outranks acceptance, so no producer sees a handshake that cycle.
   assign xfer = load && found && !Reset;

   always_comb begin
      In_Ready = '0;
      for (int unsigned i = 0; i < N; i++) begin
         In_Ready[i] = xfer && (grant == SEL_W'(i));
      end
   end

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant == SEL_W'(i)) sel_data = In[i*WIDTH +: WIDTH];
      end
   end

   // Output register occupancy FSM.
   always_ff @(posedge CLK) begin
      if (Reset) state <= ST_EMPTY;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (load) state_next = found ? ST_FULL : ST_EMPTY;
   end

   always_comb begin
      Out_Valid = (state == ST_FULL);
   end

   // Data, source index and round-robin pointer.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         Out     <= '0;
         Out_Sel <= '0;
         rr_ptr  <= '0;
      end else if (xfer) begin
         Out     <= sel_data;
         Out_Sel <= grant;
         if (Mode == MODE_RR) begin
            rr_ptr <= (grant == SEL_W'(N-1)) ? '0 : grant + SEL_W'(1);
         end
      end
   end

endmodule
